msdap_serial_rx: RTL and testbench
==================================

# msdap_serial_rx

Serial-to-parallel front end for the stereo audio processor. It deserializes two MSB-first serial audio streams (left and right), which share one Dclk and one Frame strobe, into 16-bit words. It presents each completed word pair as InputL/InputR with a one-cycle valid strobe to the input-capture stage of the processor core. It also detects framing violations and counts delivered word pairs.

## Interface
Parameters:
- WIDTH, 16, bits per audio word (minimum 2)
- CNT_W, 16, width of the delivered-word counter

Ports:
- Dclk  in  1  data clock; all state changes on the rising edge
- Reset_n  in  1  synchronous active-low reset, sampled on the Dclk rising edge
- Enable  in  1  receive enable, driven from the core's InReady
- Frame  in  1  high for exactly the Dclk cycle carrying each word's MSB
- SerialL  in  1  left serial data bit
- SerialR  in  1  right serial data bit
- clear_err  in  1  clears frame_err
- InputL  out  WIDTH  last completed left word
- InputR  out  WIDTH  last completed right word
- word_valid  out  1  one-cycle pulse when InputL/InputR update
- busy  out  1  high while a word is being shifted in
- frame_err  out  1  sticky framing-error flag
- word_count  out  CNT_W  saturating count of word_valid pulses

## Operation
- FSM states:
  - WAIT_FRAME, entered on reset.
  - SHIFT.
- Bit counter cnt, range 0..WIDTH-1.
- Shift registers: shL and shR, each WIDTH-1 bits. They capture the bits before the last one.
- WAIT_FRAME transitions:
  - Enable=1 and Frame=1: load the MSB into shL/shR, set cnt=1, go to SHIFT.
  - Otherwise stay. Serial inputs are ignored.
- SHIFT transitions:
  - Enable=0: go to WAIT_FRAME and discard the partial word. No error, no valid.
  - Frame=1 (early frame, any cnt 1..WIDTH-1): set frame_err and discard the partial word. Treat this bit as a new MSB: reload shL/shR, set cnt=1, stay in SHIFT.
  - Otherwise, when cnt<WIDTH-1: shift the bit in and increment cnt.
  - Otherwise, when cnt=WIDTH-1 (final/LSB bit): load InputL={shL,SerialL} and InputR={shR,SerialR}, pulse word_valid, increment word_count, and go to WAIT_FRAME.
- Back-to-back words:
  - Frame in the cycle immediately after the LSB is sampled in WAIT_FRAME and starts a new word, so no idle gap is required.
- Frame while Enable=0 is ignored in every state.
- Simultaneous events:
  - clear_err and a new framing error in the same cycle: the error wins and frame_err stays 1.
  - Enable=0 and Frame=1 in SHIFT: the abort wins and no error is flagged.
- word_count saturates at 2^CNT_W-1 and never wraps.
- InputL/InputR hold their value between completions. Partial words never reach them.
- busy = (state==SHIFT).

## Timing
- Reset values, applied on the first Dclk edge with Reset_n=0:
  - State WAIT_FRAME, cnt=0, shift registers 0.
  - InputL=0, InputR=0, word_valid=0, busy=0, frame_err=0, word_count=0.
- Reset mid-word discards all progress. The first word after reset requires a fresh Frame.
- Edge E0 samples the MSB with Frame=1. Edges E1..E(WIDTH-1) sample the remaining bits.
- At edge E(WIDTH-1):
  - InputL/InputR/word_count update.
  - word_valid rises and is deasserted at edge E(WIDTH).
- Latency: the word is visible 0 cycles after its LSB edge, and WIDTH-1 cycles after the Frame edge.
- Maximum throughput: one word pair per WIDTH Dclk cycles.
- frame_err sets on the edge that samples the early Frame. It clears on the edge after clear_err=1 when no new error occurs on that edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Basic word: Reset, then Enable=1, Frame at E0, SerialL=0xA5C3, SerialR=0x1234 MSB-first.
  - Required: word_valid pulse exactly at E15, InputL=0xA5C3, InputR=0x1234, word_count=1, frame_err=0.
- Back-to-back: three consecutive frames, 48 cycles, words 0xFFFF/0x0000, 0x8001/0x7FFE, 0x0F0F/0xF0F0.
  - Required: three word_valid pulses 16 cycles apart, correct values each time, word_count=3.
- Early frame: Frame at E0, then a second Frame at E9 followed by 15 bits of 0x5555/0xAAAA.
  - Required: frame_err=1 from E9; no valid for the aborted word; valid with 0x5555/0xAAAA at E9+15.
  - Then clear_err and an early Frame on the same edge: frame_err stays 1.
- Enable drop: Enable=0 at E7 of a word.
  - Required: busy=0 next cycle, no word_valid, InputL/InputR keep their prior values, frame_err=0.
  - Frame with Enable=0 produces no activity.
- Reset mid-word: Reset_n=0 at E10.
  - Required: all outputs at reset values after that edge.
  - The next full frame delivers a correct word with word_count=1.
- Saturation: with CNT_W=4, deliver 17 words.
  - Required: word_count sticks at 15 and every word is still delivered.

Source files
------------

// File: rtl/msdap_serial_rx.sv
// rtl/msdap_serial_rx.sv - stereo serial-to-parallel audio word receiver
//
// Purpose:
//   Deserializes two MSB-first serial streams (left/right) that share Dclk and
//   a Frame strobe into WIDTH-bit words. It presents each completed pair on
//   InputL/InputR with a one-cycle word_valid pulse. It flags early Frame
//   strobes in a sticky frame_err and counts delivered pairs, saturating.
//
// Ports:
//   Dclk        in   data clock, all state changes on the rising edge
//   Reset_n     in   synchronous active-low reset
//   Enable      in   receive enable (core InReady)
//   Frame       in   high on the cycle carrying a word's MSB
//   SerialL/R   in   left/right serial data bits
//   clear_err   in   clears frame_err (a simultaneous new error wins)
//   InputL/R    out  last completed left/right word
//   word_valid  out  one-cycle pulse when InputL/InputR update
//   busy        out  high while a word is being shifted in
//   frame_err   out  sticky framing-error flag
//   word_count  out  saturating count of delivered word pairs

module msdap_serial_rx #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             Dclk,
    input  logic             Reset_n,
    input  logic             Enable,
    input  logic             Frame,
    input  logic             SerialL,
    input  logic             SerialR,
    input  logic             clear_err,
    output logic [WIDTH-1:0] InputL,
    output logic [WIDTH-1:0] InputR,
    output logic             word_valid,
    output logic             busy,
    output logic             frame_err,
    output logic [CNT_W-1:0] word_count
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic ST_WAIT_FRAME = 1'b0;
    localparam logic ST_SHIFT      = 1'b1;

    logic             state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-2:0] shl_q, shl_d;
    logic [WIDTH-2:0] shr_q, shr_d;
    logic [WIDTH-1:0] input_l_q, input_l_d;
    logic [WIDTH-1:0] input_r_q, input_r_d;
    logic             word_valid_q, word_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic             err_set;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shl_d        = shl_q;
        shr_d        = shr_q;
        input_l_d    = input_l_q;
        input_r_d    = input_r_q;
        word_valid_d = 1'b0;
        word_count_d = word_count_q;
        err_set      = 1'b0;

        case (state_q)
            ST_WAIT_FRAME: begin
                if (Enable && Frame) begin
                    shl_d    = '0;
                    shl_d[0] = SerialL;
                    shr_d    = '0;
                    shr_d[0] = SerialR;
                    cnt_d    = CW'(1);
                    state_d  = ST_SHIFT;
                end
            end
            default: begin
                if (!Enable) begin
                    // Abort takes priority over a coincident Frame: no error.
                    state_d = ST_WAIT_FRAME;
                    cnt_d   = '0;
                end else if (Frame) begin
                    // Early frame: drop the partial word and restart on this MSB.
                    err_set  = 1'b1;
                    shl_d    = '0;
                    shl_d[0] = SerialL;
                    shr_d    = '0;
                    shr_d[0] = SerialR;
                    cnt_d    = CW'(1);
                end else if (cnt_q != CNT_LAST) begin
                    shl_d    = shl_q << 1;
                    shl_d[0] = SerialL;
                    shr_d    = shr_q << 1;
                    shr_d[0] = SerialR;
                    cnt_d    = cnt_q + CW'(1);
                end else begin
                    // LSB edge: the word completes straight from the shifters.
                    input_l_d    = {shl_q, SerialL};
                    input_r_d    = {shr_q, SerialR};
                    word_valid_d = 1'b1;
                    if (word_count_q != {CNT_W{1'b1}}) begin
                        word_count_d = word_count_q + CNT_W'(1);
                    end
                    state_d = ST_WAIT_FRAME;
                    cnt_d   = '0;
                end
            end
        endcase

        frame_err_d = frame_err_q;
        if (clear_err) begin
            frame_err_d = 1'b0;
        end
        if (err_set) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge Dclk) begin
        if (!Reset_n) begin
            state_q      <= ST_WAIT_FRAME;
            cnt_q        <= '0;
            shl_q        <= '0;
            shr_q        <= '0;
            input_l_q    <= '0;
            input_r_q    <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shl_q        <= shl_d;
            shr_q        <= shr_d;
            input_l_q    <= input_l_d;
            input_r_q    <= input_r_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
            word_count_q <= word_count_d;
        end
    end

    assign InputL     = input_l_q;
    assign InputR     = input_r_q;
    assign word_valid = word_valid_q;
    assign busy       = (state_q == ST_SHIFT);
    assign frame_err  = frame_err_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_msdap_serial_rx.sv
// tb/tb_msdap_serial_rx.sv - directed self-checking bench for msdap_serial_rx

module tb_msdap_serial_rx;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    logic             Dclk = 1'b0;
    logic             Reset_n;
    logic             Enable;
    logic             Frame;
    logic             SerialL;
    logic             SerialR;
    logic             clear_err;
    logic [WIDTH-1:0] InputL;
    logic [WIDTH-1:0] InputR;
    logic             word_valid;
    logic             busy;
    logic             frame_err;
    logic [CNT_W-1:0] word_count;

    int n_cmp = 0;
    int n_err = 0;

    msdap_serial_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Dclk       (Dclk),
        .Reset_n    (Reset_n),
        .Enable     (Enable),
        .Frame      (Frame),
        .SerialL    (SerialL),
        .SerialR    (SerialR),
        .clear_err  (clear_err),
        .InputL     (InputL),
        .InputR     (InputR),
        .word_valid (word_valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .word_count (word_count)
    );

    always #5 Dclk = ~Dclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one bit, then step past the rising edge; outputs are sampled #1 later.
    task automatic bit_cycle(input logic f, input logic sl, input logic sr);
        Frame   = f;
        SerialL = sl;
        SerialR = sr;
        @(posedge Dclk);
        #1;
    endtask

    // Full word starting with Frame; word_valid must appear only on the LSB edge.
    task automatic send_word(input logic [15:0] l, input logic [15:0] r, input string tag);
        for (int i = 0; i < WIDTH; i++) begin
            bit_cycle(i == 0, l[WIDTH-1-i], r[WIDTH-1-i]);
            check({tag, "_valid"}, {31'd0, word_valid}, {31'd0, i == WIDTH - 1});
        end
        check({tag, "_L"}, {16'd0, InputL}, {16'd0, l});
        check({tag, "_R"}, {16'd0, InputR}, {16'd0, r});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_L"},     {16'd0, InputL}, 32'd0);
        check({tag, "_R"},     {16'd0, InputR}, 32'd0);
        check({tag, "_valid"}, {31'd0, word_valid}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_err"},   {31'd0, frame_err}, 32'd0);
        check({tag, "_cnt"},   {28'd0, word_count}, 32'd0);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        bit_cycle(1'b0, 1'b0, 1'b0);
        Reset_n = 1'b1;
    endtask

    initial begin
        logic [15:0] wl;
        logic [15:0] wr;
        Reset_n   = 1'b0;
        Enable    = 1'b0;
        Frame     = 1'b0;
        SerialL   = 1'b0;
        SerialR   = 1'b0;
        clear_err = 1'b0;
        #2;
        do_reset();
        check_reset_outputs("reset");
        Enable = 1'b1;

        // Basic word
        send_word(16'hA5C3, 16'h1234, "basic");
        check("basic_cnt", {28'd0, word_count}, 32'd1);
        check("basic_err", {31'd0, frame_err}, 32'd0);
        bit_cycle(1'b0, 1'b0, 1'b0);
        check("basic_valid_drop", {31'd0, word_valid}, 32'd0);
        check("basic_idle_busy", {31'd0, busy}, 32'd0);

        // Back-to-back, no idle gap
        do_reset();
        send_word(16'hFFFF, 16'h0000, "b2b0");
        send_word(16'h8001, 16'h7FFE, "b2b1");
        send_word(16'h0F0F, 16'hF0F0, "b2b2");
        check("b2b_cnt", {28'd0, word_count}, 32'd3);

        // Early frame at E9, new word 0x5555/0xAAAA completes at E9+15
        wl = 16'h5555;
        wr = 16'hAAAA;
        bit_cycle(1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 9; i++) begin
            bit_cycle(1'b0, 1'b1, 1'b0);
            check("early_pre_valid", {31'd0, word_valid}, 32'd0);
        end
        check("early_pre_err", {31'd0, frame_err}, 32'd0);
        bit_cycle(1'b1, wl[15], wr[15]);
        check("early_err_E9", {31'd0, frame_err}, 32'd1);
        check("early_valid_E9", {31'd0, word_valid}, 32'd0);
        check("early_busy_E9", {31'd0, busy}, 32'd1);
        for (int i = 14; i >= 0; i--) begin
            bit_cycle(1'b0, wl[i], wr[i]);
            check("early_valid", {31'd0, word_valid}, {31'd0, i == 0});
        end
        check("early_L", {16'd0, InputL}, 32'h5555);
        check("early_R", {16'd0, InputR}, 32'hAAAA);
        check("early_cnt", {28'd0, word_count}, 32'd4);

        // clear_err on the same edge as a new early frame: error wins
        bit_cycle(1'b1, 1'b0, 1'b0);
        bit_cycle(1'b0, 1'b0, 1'b0);
        clear_err = 1'b1;
        bit_cycle(1'b1, 1'b0, 1'b0);
        check("clr_vs_err", {31'd0, frame_err}, 32'd1);
        // clear_err alone while aborting clears the flag
        Enable = 1'b0;
        bit_cycle(1'b0, 1'b0, 1'b0);
        clear_err = 1'b0;
        check("clr_alone", {31'd0, frame_err}, 32'd0);
        check("clr_busy", {31'd0, busy}, 32'd0);
        Enable = 1'b1;

        // Enable drop at E7
        bit_cycle(1'b1, 1'b0, 1'b1);
        for (int i = 1; i < 7; i++) begin
            bit_cycle(1'b0, 1'b1, 1'b0);
        end
        check("endrop_busy_pre", {31'd0, busy}, 32'd1);
        Enable = 1'b0;
        bit_cycle(1'b1, 1'b1, 1'b1);
        check("endrop_busy", {31'd0, busy}, 32'd0);
        check("endrop_err", {31'd0, frame_err}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            bit_cycle(i[0], 1'b1, 1'b0);
            check("endrop_valid", {31'd0, word_valid}, 32'd0);
            check("endrop_idle_busy", {31'd0, busy}, 32'd0);
        end
        check("endrop_L", {16'd0, InputL}, 32'h5555);
        check("endrop_R", {16'd0, InputR}, 32'hAAAA);
        check("endrop_cnt", {28'd0, word_count}, 32'd4);
        Enable = 1'b1;

        // Reset at E10 mid-word
        bit_cycle(1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 10; i++) begin
            bit_cycle(1'b0, 1'b1, 1'b1);
        end
        Reset_n = 1'b0;
        bit_cycle(1'b0, 1'b1, 1'b1);
        check_reset_outputs("midrst");
        Reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bit_cycle(1'b0, 1'b1, 1'b1);
            check("midrst_no_resume", {31'd0, busy}, 32'd0);
        end
        send_word(16'h1357, 16'h2468, "postrst");
        check("postrst_cnt", {28'd0, word_count}, 32'd1);

        // Saturation: 17 words with CNT_W=4
        do_reset();
        for (int i = 0; i < 17; i++) begin
            wl = 16'h1000 + 16'(i * 3);
            wr = ~wl;
            send_word(wl, wr, "sat");
            if (i == 14) check("sat_cnt15", {28'd0, word_count}, 32'd15);
        end
        check("sat_cnt_hold", {28'd0, word_count}, 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
